// File: rtl/uart_xcvr_fifo.sv
// UART transceiver with TX/RX FIFOs, configurable framing,
// per-entry error flags and sticky RX overrun.
module uart_xcvr_fifo #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_busy,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  input  logic                          rx_rd,
  output logic                          rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_overrun,
  input  logic                          clear_err,
  input  logic                          uart_rxd,
  output logic                          uart_txd
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int DIV_R = (clk_freq + 8 * uart_baud_rate)
                         / (16 * uart_baud_rate);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW    = DATA_BITS + 2;
  localparam logic POD = (PARITY == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_BRK   = 3'd5;

  logic [CW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div_q <= '0;
    else             div_q <= div_q + 1'b1;
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW:0]          tx_wp, tx_rp;
  logic                 tx_push, tx_pop, tx_empty;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_level = tx_wp - tx_rp;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_level == (AW+1)'(FIFO_DEPTH));
  assign tx_push  = tx_wr && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // TX shifter
  logic [2:0]           tx_st;
  logic [3:0]           tx_tc;
  logic [2:0]           tx_bc;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_pb, txd_q, tx_end, tx_last;

  assign tx_end  = tick && (tx_tc == 4'd15);
  assign tx_last = (tx_bc == 3'(STOP_BITS - 1));
  // A waiting byte is chained straight from the last stop bit.
  assign tx_pop  = !tx_empty && ((tx_st == S_IDLE) ||
                   (tx_st == S_STOP && tx_end && tx_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st <= S_IDLE;
      tx_tc <= '0;
      tx_bc <= '0;
      tx_sh <= '0;
      tx_pb <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      if (tick) tx_tc <= tx_tc + 4'd1;
      if (tx_pop) begin
        tx_sh <= tx_head;
        tx_pb <= (^tx_head) ^ POD;
        tx_st <= S_START;
        tx_tc <= '0;
        txd_q <= 1'b0;
      end else begin
        case (tx_st)
          S_START: if (tx_end) begin
            tx_st <= S_DATA;
            tx_bc <= '0;
            txd_q <= tx_sh[0];
          end
          S_DATA: if (tx_end) begin
            if (tx_bc == 3'(DATA_BITS - 1)) begin
              tx_bc <= '0;
              if (PARITY != 0) begin
                tx_st <= S_PAR;
                txd_q <= tx_pb;
              end else begin
                tx_st <= S_STOP;
                txd_q <= 1'b1;
              end
            end else begin
              tx_bc <= tx_bc + 3'd1;
              tx_sh <= tx_sh >> 1;
              txd_q <= tx_sh[1];
            end
          end
          S_PAR: if (tx_end) begin
            tx_st <= S_STOP;
            tx_bc <= '0;
            txd_q <= 1'b1;
          end
          S_STOP: if (tx_end) begin
            if (tx_last) tx_st <= S_IDLE;
            else         tx_bc <= tx_bc + 3'd1;
          end
          default: begin
            tx_st <= S_IDLE;
            txd_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (tx_st != S_IDLE) || !tx_empty;

  // RX synchroniser and edge history
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  logic [2:0]           rx_st;
  logic [3:0]           rx_tc;
  logic [2:0]           rx_bc;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pb, rx_mid, rx_req, rx_perr;

  assign rx_mid  = tick && (rx_tc == 4'd15);
  assign rx_req  = (rx_st == S_STOP) && rx_mid;
  assign rx_perr = (PARITY != 0) && (rx_pb != ((^rx_sh) ^ POD));

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st <= S_IDLE;
      rx_tc <= '0;
      rx_bc <= '0;
      rx_sh <= '0;
      rx_pb <= 1'b0;
    end else begin
      if (tick) rx_tc <= rx_tc + 4'd1;
      case (rx_st)
        S_IDLE: if (rx_prev && !rx_s2) begin
          rx_st <= S_START;
          rx_tc <= '0;
        end
        S_START: if (tick && rx_tc == 4'd7) begin
          rx_tc <= '0;
          rx_bc <= '0;
          rx_st <= rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_mid) begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bc == 3'(DATA_BITS - 1))
            rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
          else
            rx_bc <= rx_bc + 3'd1;
        end
        S_PAR: if (rx_mid) begin
          rx_pb <= rx_s2;
          rx_st <= S_STOP;
        end
        S_STOP: if (rx_mid) rx_st <= rx_s2 ? S_IDLE : S_BRK;
        S_BRK:  if (rx_s2)  rx_st <= S_IDLE;
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // RX FIFO entries are {parity_err, frame_err, data}
  logic [RW-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]   rx_wp, rx_rp;
  logic          rx_push, rx_pop, rx_full;
  logic [RW-1:0] rx_head;

  assign rx_level = rx_wp - rx_rp;
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_level == (AW+1)'(FIFO_DEPTH));
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_push  = rx_req && (!rx_full || rx_pop);
  assign rx_head  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= {rx_perr, !rx_s2, rx_sh};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_req && !rx_push) rx_overrun <= 1'b1;
      else if (clear_err)     rx_overrun <= 1'b0;
    end
  end

  assign rx_data       = rx_head[DATA_BITS-1:0];
  assign rx_frame_err  = rx_head[DATA_BITS];
  assign rx_parity_err = rx_head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_xcvr_fifo.sv
// Bench for uart_xcvr_fifo: unit 0 is 8N1, unit 1 is 8E1,
// unit 2 is 8O2; all at 100 MHz / 1152000 (80 clocks per bit).
module tb_uart_xcvr_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] tx_data [3];
  logic       tx_wr [3];
  logic       tx_full [3];
  logic [4:0] tx_level [3];
  logic       tx_busy [3];
  logic [7:0] rx_data [3];
  logic       rx_fe [3];
  logic       rx_pe [3];
  logic       rx_rd [3];
  logic       rx_empty [3];
  logic [4:0] rx_level [3];
  logic       rx_ovr [3];
  logic       clear_err [3];
  logic       rxd [3];
  logic       txd [3];
  logic       drv [3];
  logic       lb [3];

  for (genvar g = 0; g < 3; g++) begin : gu
    uart_xcvr_fifo #(
      .PARITY   (g == 0 ? 0 : (g == 1 ? 2 : 1)),
      .STOP_BITS(g == 2 ? 2 : 1)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_data      (tx_data[g]),
      .tx_wr        (tx_wr[g]),
      .tx_full      (tx_full[g]),
      .tx_level     (tx_level[g]),
      .tx_busy      (tx_busy[g]),
      .rx_data      (rx_data[g]),
      .rx_frame_err (rx_fe[g]),
      .rx_parity_err(rx_pe[g]),
      .rx_rd        (rx_rd[g]),
      .rx_empty     (rx_empty[g]),
      .rx_level     (rx_level[g]),
      .rx_overrun   (rx_ovr[g]),
      .clear_err    (clear_err[g]),
      .uart_rxd     (rxd[g]),
      .uart_txd     (txd[g])
    );
    assign rxd[g] = lb[g] ? txd[g] : drv[g];
  end

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  typedef struct {
    int         u;
    bit         lbk;
    logic [7:0] d;
    bit         bp;
    bit         bs;
    logic [7:0] ed;
    bit         ef;
    bit         ep;
  } vec_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(int u, logic [7:0] d);
    tx_data[u] = d;
    tx_wr[u] = 1'b1;
    cyc(1);
    tx_wr[u] = 1'b0;
  endtask

  task automatic wait_fall(int u);
    int n = 0;
    while (txd[u] !== 1'b0 && n < 3000) begin
      cyc(1);
      n++;
    end
    chk($sformatf("txd_fall_u%0d", u), txd[u], 0);
  endtask

  task automatic push_exp(logic [7:0] d, logic fe, logic pe);
    exp_t e;
    e.d = d;
    e.fe = fe;
    e.pe = pe;
    sbq.push_back(e);
  endtask

  task automatic pop_check(int u, string nm);
    exp_t e;
    int n = 0;
    while (rx_empty[u] && n < 4000) begin
      cyc(1);
      n++;
    end
    chk({nm, "_avail"}, rx_empty[u], 0);
    if (!rx_empty[u]) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s_unexpected: got %0h want none", nm, rx_data[u]);
      end else begin
        e = sbq.pop_front();
        chk({nm, "_data"}, rx_data[u], e.d);
        chk({nm, "_ferr"}, rx_fe[u], e.fe);
        chk({nm, "_perr"}, rx_pe[u], e.pe);
      end
      rx_rd[u] = 1'b1;
      cyc(1);
      rx_rd[u] = 1'b0;
    end
  endtask

  task automatic drive_frame(int u, logic [7:0] d, bit bp, bit bs);
    int pm = (u == 0) ? 0 : ((u == 1) ? 2 : 1);
    int ns = (u == 2) ? 2 : 1;
    logic p;
    drv[u] = 1'b1;
    lb[u] = 1'b0;
    cyc(2);
    drv[u] = 1'b0;
    cyc(80);
    for (int i = 0; i < 8; i++) begin
      drv[u] = d[i];
      cyc(80);
    end
    if (pm != 0) begin
      p = (^d) ^ (pm == 1);
      drv[u] = p ^ bp;
      cyc(80);
    end
    if (bs) begin
      drv[u] = 1'b0;
      cyc(80 * 4);
    end else begin
      drv[u] = 1'b1;
      cyc(80 * ns);
    end
    drv[u] = 1'b1;
    cyc(160);
    lb[u] = 1'b1;
  endtask

  vec_t vt [12];

  initial begin
    logic [9:0] wb;
    int lat;
    int maxl;
    int frames;
    bit fseen;

    vt[0]  = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 0};
    vt[1]  = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0, 0};
    vt[2]  = '{0, 1, 8'h3C, 0, 0, 8'h3C, 0, 0};
    vt[3]  = '{0, 0, 8'h5A, 0, 1, 8'h5A, 1, 0};
    vt[4]  = '{0, 0, 8'h3C, 0, 0, 8'h3C, 0, 0};
    vt[5]  = '{1, 0, 8'hA5, 0, 0, 8'hA5, 0, 0};
    vt[6]  = '{1, 0, 8'hA5, 1, 0, 8'hA5, 0, 1};
    vt[7]  = '{1, 1, 8'hC3, 0, 0, 8'hC3, 0, 0};
    vt[8]  = '{2, 0, 8'hA5, 0, 0, 8'hA5, 0, 0};
    vt[9]  = '{2, 0, 8'hA5, 1, 0, 8'hA5, 0, 1};
    vt[10] = '{2, 1, 8'h81, 0, 0, 8'h81, 0, 0};
    vt[11] = '{1, 0, 8'h01, 0, 1, 8'h01, 1, 0};

    for (int u = 0; u < 3; u++) begin
      tx_data[u] = '0;
      tx_wr[u] = 1'b0;
      rx_rd[u] = 1'b0;
      clear_err[u] = 1'b0;
      drv[u] = 1'b1;
      lb[u] = 1'b1;
    end
    cyc(4);
    rst = 1'b0;
    cyc(1);

    chk("rst_txd", txd[0], 1);
    chk("rst_tx_full", tx_full[0], 0);
    chk("rst_tx_busy", tx_busy[0], 0);
    chk("rst_tx_level", tx_level[0], 0);
    chk("rst_rx_empty", rx_empty[0], 1);
    chk("rst_rx_level", rx_level[0], 0);
    chk("rst_rx_ovr", rx_ovr[0], 0);
    chk("rst_rx_data", rx_data[0], 0);
    chk("rst_rx_fe", rx_fe[0], 0);
    chk("rst_rx_pe", rx_pe[0], 0);

    // 0xA5 waveform and receive latency on the 8N1 loopback
    wb = {1'b1, 8'hA5, 1'b0};
    lat = -1;
    wr(0, 8'hA5);
    wait_fall(0);
    for (int t = 0; t < 950; t++) begin
      if (t % 80 == 40 && t < 800)
        chk($sformatf("wave_bit%0d", t / 80), txd[0], wb[t / 80]);
      if (lat < 0 && !rx_empty[0]) lat = t;
      cyc(1);
    end
    total++;
    if (lat < 740 || lat > 785) begin
      bad++;
      $display("FAIL rx_latency: got %0d want 740..785", lat);
    end
    push_exp(8'hA5, 0, 0);
    pop_check(0, "wave_rx");

    // Parity bit on the line: even -> 0, odd -> 1 for 0xA5
    wr(1, 8'hA5);
    wait_fall(1);
    cyc(40 + 80 * 9);
    chk("par_even_bit", txd[1], 0);
    push_exp(8'hA5, 0, 0);
    pop_check(1, "par_even_rx");
    wr(2, 8'hA5);
    wait_fall(2);
    cyc(40 + 80 * 9);
    chk("par_odd_bit", txd[2], 1);
    push_exp(8'hA5, 0, 0);
    pop_check(2, "par_odd_rx");

    for (int i = 0; i < 12; i++) begin
      if (vt[i].lbk) begin
        wr(vt[i].u, vt[i].d);
        cyc(1200);
      end else begin
        drive_frame(vt[i].u, vt[i].d, vt[i].bp, vt[i].bs);
      end
      push_exp(vt[i].ed, vt[i].ef, vt[i].ep);
      chk($sformatf("vec%0d_level", i), rx_level[vt[i].u], 1);
      pop_check(vt[i].u, $sformatf("vec%0d", i));
    end

    // RX overrun: 17 frames, nothing read
    for (int i = 0; i < 17; i++) begin
      tx_data[0] = 8'(8'h10 + i);
      tx_wr[0] = 1'b1;
      cyc(1);
    end
    tx_wr[0] = 1'b0;
    for (int i = 0; i < 16; i++) push_exp(8'(8'h10 + i), 0, 0);
    cyc(17 * 800 + 1000);
    chk("ovr_level", rx_level[0], 16);
    chk("ovr_flag", rx_ovr[0], 1);
    chk("ovr_head", rx_data[0], 8'h10);
    clear_err[0] = 1'b1;
    cyc(1);
    clear_err[0] = 1'b0;
    chk("ovr_clear", rx_ovr[0], 0);
    for (int i = 0; i < 16; i++) pop_check(0, $sformatf("ovr_drain%0d", i));
    chk("ovr_drained", rx_empty[0], 1);

    // 18 writes on consecutive cycles: one is lost to a full FIFO
    maxl = 0;
    fseen = 0;
    for (int i = 0; i < 18; i++) begin
      tx_data[0] = 8'(8'h40 + i);
      tx_wr[0] = 1'b1;
      cyc(1);
      if (int'(tx_level[0]) > maxl) maxl = int'(tx_level[0]);
      if (tx_full[0]) fseen = 1;
    end
    tx_wr[0] = 1'b0;
    for (int i = 0; i < 17; i++) push_exp(8'(8'h40 + i), 0, 0);
    frames = 0;
    for (int t = 0; t < 15500; t++) begin
      if (int'(tx_level[0]) > maxl) maxl = int'(tx_level[0]);
      if (!rx_empty[0]) begin
        frames++;
        pop_check(0, $sformatf("burst%0d", frames));
      end else begin
        cyc(1);
      end
    end
    chk("burst_frames", frames, 17);
    chk("burst_max_level", maxl, 16);
    chk("burst_full_seen", fseen, 1);
    chk("burst_sb_left", sbq.size(), 0);

    // Reset in the middle of a TX data bit
    wr(0, 8'h77);
    wr(0, 8'h78);
    wait_fall(0);
    cyc(80 * 3 + 40);
    chk("mid_pre_level", tx_level[0], 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mid_txd", txd[0], 1);
    chk("mid_tx_level", tx_level[0], 0);
    chk("mid_tx_busy", tx_busy[0], 0);
    cyc(1500);
    chk("mid_rx_empty", rx_empty[0], 1);
    chk("mid_rx_level", rx_level[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_xcvr_fifo.md
Name: uart_xcvr_fifo

Overview:
- Parametrised UART transceiver with TX and RX FIFOs; successor to the fixed 8N1 UART used in the lm32 system.
- Adds configurable data width, parity, stop bits and FIFO depth, plus per-byte error flags and overrun detection.
- Sits between the SoC bus wrapper (or a testbench driver) and the uart_rxd/uart_txd pins.
- Also instantiated in system_tb as the simulated comm partner.

Parameters:
- clk_freq, 100000000, clock frequency in Hz.
- uart_baud_rate, 1152000, line baud rate.
- DATA_BITS, 8, bits per character (5..8).
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits (1 or 2).
- FIFO_DEPTH, 16, entries per FIFO (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tx_data  in  DATA_BITS  byte to transmit.
- tx_wr  in  1  push tx_data into TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_level  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy.
- tx_busy  out  1  shifter active or TX FIFO non-empty.
- rx_data  out  DATA_BITS  RX FIFO head (first-word-fall-through).
- rx_frame_err  out  1  head entry had stop-bit error.
- rx_parity_err  out  1  head entry had parity error.
- rx_rd  in  1  pop RX FIFO head.
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  clog2(FIFO_DEPTH)+1  RX FIFO occupancy.
- rx_overrun  out  1  sticky; a frame was dropped because the RX FIFO was full.
- clear_err  in  1  clears rx_overrun.
- uart_rxd  in  1  serial input (asynchronous).
- uart_txd  out  1  serial output.

Behaviour:
- Reset values:
  - uart_txd=1; tx_full=0; tx_busy=0; tx_level=0.
  - rx_empty=1; rx_level=0; rx_overrun=0.
  - rx_data, rx_frame_err, rx_parity_err = 0.
  - Both FSMs in IDLE; FIFOs emptied; in-flight frames abandoned.
  - uart_txd is high from the first cycle after rst is sampled.
- Baud tick:
  - DIV = round(clk_freq / (16*uart_baud_rate)), minimum 1.
  - A free-running counter produces a 1-cycle tick16 every DIV clocks; 1 bit = 16 ticks.
- FIFOs:
  - tx_wr while tx_full: ignored, data lost, no error.
  - rx_rd while rx_empty: ignored.
  - Simultaneous push and pop on a full or empty FIFO both take effect correctly (level unchanged when full).
  - Levels update 1 cycle after the push/pop edge.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the TX FIFO is non-empty, pop into the shifter and go to START; uart_txd stays 1 while in IDLE.
  - START: txd=0 for 16 ticks.
  - DATA: LSB first, DATA_BITS bits.
  - PARITY: entered only if PARITY!=0. Odd: XOR of data bits inverted. Even: XOR of data bits.
  - STOP: txd=1 for 16*STOP_BITS ticks, then IDLE.
  - Back-to-back frames have no extra idle gap beyond the stop bits.
- RX path:
  - uart_rxd passes through a 2-flop synchroniser.
  - RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a synchronised 1->0 transition goes to START.
  - START: sample at tick 8. If the line is high, treat as a false start and return to IDLE; no push.
  - DATA, PARITY: sample at mid-bit (every 16 ticks after the start-bit centre).
  - STOP: sample only the first stop bit.
- End of frame:
  - On the stop-bit sample, push {data, frame_err = stop==0, parity_err = parity mismatch}.
  - If the RX FIFO is full, drop the frame and set rx_overrun.
  - If stop==0, go to BREAK and wait for the line to go high before returning to IDLE; otherwise go to IDLE.
- rx_overrun:
  - Cleared by clear_err.
  - If clear_err and a new overrun occur in the same cycle, the set wins.
- Parity disabled: rx_parity_err is always 0.

Test Plan:
- Loopback, 8N1, txd tied to rxd, 100 MHz / 1152000 (DIV=5, 80 clk/bit):
  - Write 0xA5 -> txd shows 0,1,0,1,0,0,1,0,1,1, 80 clocks each.
  - rx_data=0xA5 with no error flags, rx_empty falls about 760 clocks after txd falls.
- PARITY=2 (even), 0xA5: parity bit 0. PARITY=1 (odd): parity bit 1.
  - Bench forces the wrong parity bit -> rx_parity_err=1 on that entry, data still 0xA5.
- Bench drives stop bit 0, then holds the line low for 3 bit times:
  - rx_frame_err=1; exactly one entry pushed.
  - Next valid frame (0x3C) is received cleanly after the line returns high.
- FIFO_DEPTH=16, no rx_rd, send 17 frames:
  - rx_level=16, rx_overrun=1, head is frame 1.
  - Pulse clear_err -> rx_overrun=0.
- Write 18 bytes on consecutive cycles:
  - tx_level never exceeds 16; tx_full asserted.
  - Exactly 17 frames appear on txd, in order.
- Assert rst for 1 cycle mid-DATA of a TX frame:
  - Next cycle uart_txd=1, tx_level=0, tx_busy=0.
  - The receiver's partial frame is discarded, with no push.
